// File: rtl/tdm4_deframer.sv
// Receive-side deframer for a 4-slot byte TDM link: SYNC, 4 slot bytes, XOR checksum.
// Slot bytes land in shadow registers and reach ch_* only when the frame's checksum matches.
//
// state | meaning
// HUNT  | searching for SYNC; non-SYNC bytes are dropped silently
// EXP   | a good frame just ended; the next byte must be SYNC
// S0-S3 | capturing slot bytes 0..3 into the shadow registers
// CHK   | comparing the checksum byte with the XOR of the shadows
module tdm4_deframer #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic [7:0] ch_w,
    output logic [7:0] ch_x,
    output logic [7:0] ch_y,
    output logic [7:0] ch_z,
    output logic       frame_valid,
    output logic       chk_err,
    output logic       sync_err,
    output logic       locked
);

    localparam logic [2:0] LOCK_CNT = 3'(LOCK_FRAMES);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_EXP,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_CHK
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0][7:0]  r_sh;
    logic [7:0]       r_ch [4];
    logic [2:0]       r_good_cnt;
    logic [2:0]       w_cnt_inc;
    logic [7:0]       w_xor;
    logic             w_frame_ok;
    logic             w_chk_fail;
    logic             w_exp_miss;
    logic             r_frame_valid;
    logic             r_chk_err;
    logic             r_sync_err;
    logic             r_locked;

    assign w_xor     = r_sh[0] ^ r_sh[1] ^ r_sh[2] ^ r_sh[3];
    assign w_cnt_inc = (r_good_cnt < LOCK_CNT) ? r_good_cnt + 3'd1 : r_good_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_ok  = 1'b0;
        w_chk_fail  = 1'b0;
        w_exp_miss  = 1'b0;
        if (din_valid) begin
            case (r_state)
                ST_HUNT: if (din == SYNC_BYTE) w_state_nxt = ST_S0;
                ST_EXP: begin
                    if (din == SYNC_BYTE) begin
                        w_state_nxt = ST_S0;
                    end else begin
                        w_state_nxt = ST_HUNT;
                        w_exp_miss  = 1'b1;
                    end
                end
                ST_S0: w_state_nxt = ST_S1;
                ST_S1: w_state_nxt = ST_S2;
                ST_S2: w_state_nxt = ST_S3;
                ST_S3: w_state_nxt = ST_CHK;
                ST_CHK: begin
                    if (din == w_xor) begin
                        w_state_nxt = ST_EXP;
                        w_frame_ok  = 1'b1;
                    end else begin
                        w_state_nxt = ST_HUNT;
                        w_chk_fail  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh          <= '0;
            r_ch          <= '{default: 8'h00};
            r_good_cnt    <= 3'd0;
            r_locked      <= 1'b0;
            r_frame_valid <= 1'b0;
            r_chk_err     <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= w_frame_ok;
            r_chk_err     <= w_chk_fail;
            // sync_err only flags a lost alignment, not an unlocked stray byte
            r_sync_err    <= w_exp_miss & r_locked;
            if (din_valid) begin
                case (r_state)
                    ST_S0:   r_sh[0] <= din;
                    ST_S1:   r_sh[1] <= din;
                    ST_S2:   r_sh[2] <= din;
                    ST_S3:   r_sh[3] <= din;
                    default: ;
                endcase
            end
            if (w_frame_ok) begin
                for (int k = 0; k < 4; k++) r_ch[k] <= r_sh[k];
                r_good_cnt <= w_cnt_inc;
                r_locked   <= (w_cnt_inc == LOCK_CNT);
            end else if (w_chk_fail || w_exp_miss) begin
                r_good_cnt <= 3'd0;
                r_locked   <= 1'b0;
            end
        end
    end

    assign ch_w        = r_ch[0];
    assign ch_x        = r_ch[1];
    assign ch_y        = r_ch[2];
    assign ch_z        = r_ch[3];
    assign frame_valid = r_frame_valid;
    assign chk_err     = r_chk_err;
    assign sync_err    = r_sync_err;
    assign locked      = r_locked;

endmodule

// File: tb/tb_tdm4_deframer.sv
// Bench for tdm4_deframer: a table of byte-by-byte vectors with expected outputs,
// followed by a hand-written mid-frame asynchronous reset sequence.
module tb_tdm4_deframer;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic [7:0] ch_w, ch_x, ch_y, ch_z;
    logic       frame_valid, chk_err, sync_err, locked;

    int errors = 0;
    int checks = 0;

    tdm4_deframer #(.SYNC_BYTE(8'hA5), .LOCK_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .ch_w(ch_w), .ch_x(ch_x), .ch_y(ch_y), .ch_z(ch_z),
        .frame_valid(frame_valid), .chk_err(chk_err), .sync_err(sync_err), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        fv;
        logic        ce;
        logic        se;
        logic        lk;
        logic [31:0] ch;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] d, input logic fv, input logic ce,
                       input logic se, input logic lk, input logic [31:0] ch);
        vec_t t;
        t.v = v; t.d = d; t.fv = fv; t.ce = ce; t.se = se; t.lk = lk; t.ch = ch;
        vecs.push_back(t);
    endtask

    // Frame with no pulses on the first five bytes; the last byte's outcome given explicitly.
    task automatic add_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                             input logic [7:0] b4, input logic [7:0] cs, input logic lk_in,
                             input logic [31:0] ch_in, input logic fv, input logic ce,
                             input logic lk_out, input logic [31:0] ch_out);
        add(1, 8'hA5, 0, 0, 0, lk_in, ch_in);
        add(1, b1,    0, 0, 0, lk_in, ch_in);
        add(1, b2,    0, 0, 0, lk_in, ch_in);
        add(1, b3,    0, 0, 0, lk_in, ch_in);
        add(1, b4,    0, 0, 0, lk_in, ch_in);
        add(1, cs,    fv, ce, 0, lk_out, ch_out);
    endtask

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got fv/ce/se/lk/ch=%b%b%b%b_%h required %b%b%b%b_%h", name,
                     act[35], act[34], act[33], act[32], act[31:0],
                     exp[35], exp[34], exp[33], exp[32], exp[31:0]);
        end
    endtask

    function automatic logic [35:0] outs();
        return {frame_valid, chk_err, sync_err, locked, ch_w, ch_x, ch_y, ch_z};
    endfunction

    task automatic step(input logic v, input logic [7:0] d);
        @(negedge clk);
        din_valid = v;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;

        // good frame, count 1: not locked yet
        add_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 0, 32'h0, 1, 0, 0, 32'h11223344);
        // back-to-back good frame reaches LOCK_FRAMES
        add_frame(8'h01, 8'h02, 8'h04, 8'h08, 8'h0F, 0, 32'h11223344, 1, 0, 1, 32'h01020408);
        // bad checksum while locked
        add_frame(8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 1, 32'h01020408, 0, 1, 0, 32'h01020408);
        // SYNC accepted from HUNT; count restarts at 1
        add_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 0, 32'h01020408, 1, 0, 0, 32'h11223344);
        add_frame(8'h01, 8'h02, 8'h04, 8'h08, 8'h0F, 0, 32'h11223344, 1, 0, 1, 32'h01020408);
        // missing SYNC while locked
        add(1, 8'h3C, 0, 0, 1, 0, 32'h01020408);
        add(1, 8'h5A, 0, 0, 0, 0, 32'h01020408);
        add_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h40, 0, 32'h01020408, 1, 0, 0, 32'h10203040);
        // missing SYNC while unlocked: no sync_err, but counter must still clear
        add(1, 8'h77, 0, 0, 0, 0, 32'h10203040);
        add(1, 8'h55, 0, 0, 0, 0, 32'h10203040);
        add(0, 8'hA5, 0, 0, 0, 0, 32'h10203040);
        // all-zero frame is valid; count 1 again, so still unlocked
        add_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 32'h10203040, 1, 0, 0, 32'h00000000);
        // SYNC-valued data with 3 idle cycles between bytes; idle din is junk
        for (int b = 0; b < 6; b++) begin
            logic [7:0] d;
            d = (b == 5) ? 8'h00 : 8'hA5;
            add(1, d, (b == 5), 0, 0, (b == 5), (b == 5) ? 32'hA5A5A5A5 : 32'h0);
            for (int g = 0; g < 3; g++)
                add(0, (g == 1) ? 8'hA5 : 8'h5C, 0, 0, 0, (b == 5), (b == 5) ? 32'hA5A5A5A5 : 32'h0);
        end

        // reset state
        #12;
        check("reset", outs(), 36'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].fv, vecs[i].ce, vecs[i].se, vecs[i].lk, vecs[i].ch});
        end

        // mid-frame reset while locked with ch=A5A5A5A5
        step(1, 8'hA5);
        step(1, 8'h11);
        step(1, 8'h22);
        check("pre_reset", outs(), {4'b0001, 32'hA5A5A5A5});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), 36'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h33);
        check("leftover0", outs(), 36'h0);
        step(1, 8'h44);
        check("leftover1", outs(), 36'h0);
        step(1, 8'h44);
        check("leftover2", outs(), 36'h0);
        step(1, 8'hA5);
        step(1, 8'h11);
        step(1, 8'h22);
        step(1, 8'h33);
        step(1, 8'h44);
        check("post_reset_s3", outs(), 36'h0);
        step(1, 8'h44);
        check("post_reset_frame", outs(), {4'b1000, 32'h11223344});
        step(0, 8'h00);
        check("pulse_end", outs(), {4'b0000, 32'h11223344});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
